crossbar_mac_array: RTL and testbench

//  Parametrised ROWS x COLS crossbar multiply-accumulate: result[c] = sum_r in[r]*weight[r][c].
//  Bit-serial shift-and-add over input bits, IN_W cycles per vector; all columns in parallel.

---
 rtl/crossbar_mac_array.sv | 188 ++++++++++++++++++
 tb/tb_crossbar_mac_array.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_mac_array.sv
// crossbar_mac_array: ROWS x COLS bit-serial multiply-accumulate crossbar.
// result[c] = sum_r in[r] * w[r][c], one input bit per cycle, all columns in parallel.
// The weight register file is writable only while idle. It is frozen during a computation.
module crossbar_mac_array #(
  parameter int IN_W   = 4,
  parameter int WT_W   = 4,
  parameter int ROWS   = 4,
  parameter int COLS   = 2,
  parameter bit SIGNED = 1'b0,
  parameter int ACC_W  = IN_W + WT_W + $clog2(ROWS),
  localparam int RA_W  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CA_W  = (COLS > 1) ? $clog2(COLS) : 1,
  localparam int CNT_W = (IN_W > 1) ? $clog2(IN_W) : 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    wt_we,
  input  logic [RA_W-1:0]         wt_row,
  input  logic [CA_W-1:0]         wt_col,
  input  logic [WT_W-1:0]         wt_data,
  output logic                    wt_err,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ROWS*IN_W-1:0]    in_vec,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [COLS*ACC_W-1:0]   result
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [ROWS*IN_W-1:0] in_q, in_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;
  logic                 wt_err_q, wt_err_d;
  logic [WT_W-1:0]      w_q [ROWS][COLS];
  logic [ACC_W-1:0]     acc_q [COLS];
  logic [ACC_W-1:0]     acc_d [COLS];
  logic [ACC_W-1:0]     col_sum_s [COLS];
  logic [ACC_W-1:0]     term_s [COLS];
  logic [IN_W-1:0]      in_row_s [ROWS];
  logic                 accept_s;
  logic                 last_bit_s;
  logic                 wt_ok_s;

  // Extend a weight to accumulator width: sign-extend in signed mode, else zero-extend.
  function automatic logic [ACC_W-1:0] wext(input logic [WT_W-1:0] w);
    logic [ACC_W-1:0] r;
    if (SIGNED) begin
      r = {{(ACC_W-WT_W){w[WT_W-1]}}, w};
    end else begin
      r = {{(ACC_W-WT_W){1'b0}}, w};
    end
    return r;
  endfunction

  assign accept_s   = (state_q == ST_IDLE) && in_valid && in_ready_q;
  assign last_bit_s = (bit_cnt_q == CNT_W'(IN_W - 1));
  assign wt_ok_s    = wt_we && (state_q == ST_IDLE) &&
                      (int'(wt_row) < ROWS) && (int'(wt_col) < COLS);

  // Next-state logic for the handshake FSM, bit counter and latched input vector.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    in_d      = in_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          state_d   = ST_COMPUTE;
          bit_cnt_d = '0;
          in_d      = in_vec;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COMPUTE: begin
        if (last_bit_s) begin
          state_d   = ST_DONE;
          bit_cnt_d = '0;
        end else begin
          state_d   = ST_COMPUTE;
          bit_cnt_d = bit_cnt_q + CNT_W'(1'b1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
      end
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
    wt_err_d    = wt_we && !wt_ok_s;
  end

  // Per-column partial sum for the current input bit, shifted into place and accumulated.
  // In signed mode the MSB of each input carries negative weight, so its term is subtracted.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      in_row_s[r] = in_q[r*IN_W +: IN_W];
    end
    for (int c = 0; c < COLS; c++) begin
      col_sum_s[c] = '0;
      for (int r = 0; r < ROWS; r++) begin
        if (in_row_s[r][bit_cnt_q]) begin
          col_sum_s[c] = col_sum_s[c] + wext(w_q[r][c]);
        end else begin
          col_sum_s[c] = col_sum_s[c];
        end
      end
      term_s[c] = col_sum_s[c] << bit_cnt_q;
      if (state_q == ST_COMPUTE) begin
        if (SIGNED && last_bit_s) begin
          acc_d[c] = acc_q[c] - term_s[c];
        end else begin
          acc_d[c] = acc_q[c] + term_s[c];
        end
      end else if (accept_s) begin
        acc_d[c] = '0;
      end else begin
        acc_d[c] = acc_q[c];
      end
    end
  end

  // Control, status and accumulator registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      in_q        <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      wt_err_q    <= 1'b0;
      for (int c = 0; c < COLS; c++) begin
        acc_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      in_q        <= in_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      wt_err_q    <= wt_err_d;
      for (int c = 0; c < COLS; c++) begin
        acc_q[c] <= acc_d[c];
      end
    end
  end

  // Weight register file: written only when idle and the address is in range.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          w_q[r][c] <= '0;
        end
      end
    end else if (wt_ok_s) begin
      w_q[wt_row][wt_col] <= wt_data;
    end
  end

  // Pack the column accumulators onto the result bus.
  always_comb begin
    for (int c = 0; c < COLS; c++) begin
      result[c*ACC_W +: ACC_W] = acc_q[c];
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign wt_err    = wt_err_q;

endmodule

// File: tb/tb_crossbar_mac_array.sv
// Directed testbench for crossbar_mac_array: unsigned 4x2, signed 4x2 and unsigned 3x2 instances
// share clock, reset and inputs; each test checks the instance it targets.
module tb_crossbar_mac_array;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        wt_we = 1'b0;
  logic [1:0]  wt_row = 2'd0;
  logic        wt_col = 1'b0;
  logic [3:0]  wt_data = 4'd0;
  logic        in_valid = 1'b0;
  logic [15:0] in_vec = 16'd0;
  logic        out_ready = 1'b1;

  logic        wt_err_a, in_ready_a, out_valid_a;
  logic        wt_err_s, in_ready_s, out_valid_s;
  logic        wt_err_t, in_ready_t, out_valid_t;
  logic [19:0] result_a, result_s, result_t;

  int checks = 0;
  int failures = 0;
  int lat;

  always #5 clock = ~clock;

  crossbar_mac_array #(.IN_W(4), .WT_W(4), .ROWS(4), .COLS(2), .SIGNED(1'b0)) dut_a (
    .clock(clock), .reset_n(reset_n), .wt_we(wt_we), .wt_row(wt_row), .wt_col(wt_col),
    .wt_data(wt_data), .wt_err(wt_err_a), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_vec(in_vec), .out_valid(out_valid_a), .out_ready(out_ready), .result(result_a));

  crossbar_mac_array #(.IN_W(4), .WT_W(4), .ROWS(4), .COLS(2), .SIGNED(1'b1)) dut_s (
    .clock(clock), .reset_n(reset_n), .wt_we(wt_we), .wt_row(wt_row), .wt_col(wt_col),
    .wt_data(wt_data), .wt_err(wt_err_s), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_vec(in_vec), .out_valid(out_valid_s), .out_ready(out_ready), .result(result_s));

  crossbar_mac_array #(.IN_W(4), .WT_W(4), .ROWS(3), .COLS(2), .SIGNED(1'b0)) dut_t (
    .clock(clock), .reset_n(reset_n), .wt_we(wt_we), .wt_row(wt_row), .wt_col(wt_col),
    .wt_data(wt_data), .wt_err(wt_err_t), .in_valid(in_valid), .in_ready(in_ready_t),
    .in_vec(in_vec[11:0]), .out_valid(out_valid_t), .out_ready(out_ready), .result(result_t));

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic write_w(input logic [1:0] r, input logic c, input logic [3:0] d);
    wt_we = 1'b1; wt_row = r; wt_col = c; wt_data = d;
    tick();
    wt_we = 1'b0;
  endtask

  task automatic start_vec(input logic [15:0] v);
    int n;
    n = 0;
    while (!in_ready_a && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready_a !== 1'b1) begin
      failures++;
      $display("FAIL start_ready_timeout: in_ready=%b want 1", in_ready_a);
    end
    in_vec = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_vec = ~v;
  endtask

  task automatic wait_done(output int l);
    l = 0;
    while (!out_valid_a && l < 20) begin
      tick();
      l++;
    end
    checks++;
    if (out_valid_a !== 1'b1) begin
      failures++;
      $display("FAIL done_timeout: out_valid=%b want 1", out_valid_a);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({in_ready_a, in_ready_s, in_ready_t, out_valid_a, out_valid_s, out_valid_t,
         wt_err_a, wt_err_s, wt_err_t} !== 9'b0 || result_a !== 20'd0 ||
        result_s !== 20'd0 || result_t !== 20'd0) begin
      failures++;
      $display("FAIL reset_state: rdy=%b%b%b ov=%b%b%b err=%b%b%b res=%h/%h/%h want all 0",
               in_ready_a, in_ready_s, in_ready_t, out_valid_a, out_valid_s, out_valid_t,
               wt_err_a, wt_err_s, wt_err_t, result_a, result_s, result_t);
    end
    reset_n = 1'b1;
    tick();
    checks++;
    if ({in_ready_a, in_ready_s, in_ready_t} !== 3'b111) begin
      failures++;
      $display("FAIL reset_release_ready: got %b want 111", {in_ready_a, in_ready_s, in_ready_t});
    end
  endtask

  task automatic test_max_unsigned;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 2; c++) begin
        write_w(2'(r), 1'(c), 4'd15);
      end
    end
    out_ready = 1'b1;
    start_vec(16'hFFFF);
    wait_done(lat);
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL max_latency: got %0d want 4", lat);
    end
    checks++;
    if (result_a !== {10'd900, 10'd900}) begin
      failures++;
      $display("FAIL max_result: got %h want %h", result_a, {10'd900, 10'd900});
    end
    tick();
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      failures++;
      $display("FAIL max_release: out_valid=%b in_ready=%b want 0 1", out_valid_a, in_ready_a);
    end
  endtask

  task automatic test_ramp;
    for (int r = 0; r < 4; r++) begin
      write_w(2'(r), 1'b0, 4'(r + 1));
      write_w(2'(r), 1'b1, 4'd0);
    end
    start_vec(16'h4321);
    wait_done(lat);
    checks++;
    if (lat != 4) begin
      failures++;
      $display("FAIL ramp_latency: got %0d want 4", lat);
    end
    checks++;
    if (result_a !== {10'd0, 10'd30}) begin
      failures++;
      $display("FAIL ramp_result: got %h want %h", result_a, {10'd0, 10'd30});
    end
    tick();
  endtask

  task automatic test_signed;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 2; c++) begin
        write_w(2'(r), 1'(c), 4'h8);
      end
    end
    start_vec(16'h8888);
    wait_done(lat);
    checks++;
    if (result_s !== {10'h100, 10'h100}) begin
      failures++;
      $display("FAIL signed_neg_neg: got %h want %h", result_s, {10'h100, 10'h100});
    end
    tick();
    start_vec(16'h7777);
    wait_done(lat);
    checks++;
    if (result_s !== {10'h320, 10'h320}) begin
      failures++;
      $display("FAIL signed_pos_neg: got %h want %h", result_s, {10'h320, 10'h320});
    end
    tick();
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    start_vec(16'h4321);
    wait_done(lat);
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (out_valid_a !== 1'b1 || in_ready_a !== 1'b0 || result_a !== {10'd80, 10'd80}) begin
        failures++;
        $display("FAIL hold_cycle%0d: ov=%b rdy=%b res=%h want 1 0 %h", i, out_valid_a,
                 in_ready_a, result_a, {10'd80, 10'd80});
      end
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      failures++;
      $display("FAIL hold_release: ov=%b rdy=%b want 0 1", out_valid_a, in_ready_a);
    end
  endtask

  task automatic test_write_on_accept;
    wt_we = 1'b1; wt_row = 2'd0; wt_col = 1'b1; wt_data = 4'd5;
    in_vec = 16'h0001;
    in_valid = 1'b1;
    tick();
    wt_we = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (wt_err_a !== 1'b0) begin
      failures++;
      $display("FAIL accept_write_err: got %b want 0", wt_err_a);
    end
    wait_done(lat);
    checks++;
    if (result_a !== {10'd5, 10'd8}) begin
      failures++;
      $display("FAIL accept_write_result: got %h want %h", result_a, {10'd5, 10'd8});
    end
    tick();
  endtask

  task automatic test_write_drop;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 2; c++) begin
        write_w(2'(r), 1'(c), 4'd1);
      end
    end
    start_vec(16'h0321);
    wait_done(lat);
    checks++;
    if (result_t !== {10'd6, 10'd6}) begin
      failures++;
      $display("FAIL rows3_base: got %h want %h", result_t, {10'd6, 10'd6});
    end
    tick();
    write_w(2'd3, 1'b0, 4'd15);
    checks++;
    if (wt_err_t !== 1'b1 || wt_err_a !== 1'b0) begin
      failures++;
      $display("FAIL range_err_pulse: t=%b a=%b want 1 0", wt_err_t, wt_err_a);
    end
    tick();
    checks++;
    if (wt_err_t !== 1'b0) begin
      failures++;
      $display("FAIL range_err_end: got %b want 0", wt_err_t);
    end
    start_vec(16'h0321);
    write_w(2'd0, 1'b0, 4'd15);
    checks++;
    if (wt_err_t !== 1'b1 || wt_err_a !== 1'b1) begin
      failures++;
      $display("FAIL busy_err_pulse: t=%b a=%b want 1 1", wt_err_t, wt_err_a);
    end
    tick();
    checks++;
    if (wt_err_t !== 1'b0) begin
      failures++;
      $display("FAIL busy_err_end: got %b want 0", wt_err_t);
    end
    wait_done(lat);
    checks++;
    if (result_t !== {10'd6, 10'd6}) begin
      failures++;
      $display("FAIL rows3_after_drop: got %h want %h", result_t, {10'd6, 10'd6});
    end
    tick();
  endtask

  task automatic test_reset_abort;
    start_vec(16'hFFFF);
    tick();
    tick();
    checks++;
    if (result_a !== {10'd33, 10'd54}) begin
      failures++;
      $display("FAIL partial_acc: got %h want %h", result_a, {10'd33, 10'd54});
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid_a !== 1'b0 || result_a !== 20'd0 || in_ready_a !== 1'b0) begin
      failures++;
      $display("FAIL abort_reset: ov=%b res=%h rdy=%b want 0 0 0", out_valid_a, result_a, in_ready_a);
    end
    tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (in_ready_a !== 1'b1) begin
      failures++;
      $display("FAIL abort_release_ready: got %b want 1", in_ready_a);
    end
    start_vec(16'hFFFF);
    wait_done(lat);
    checks++;
    if (result_a !== 20'd0) begin
      failures++;
      $display("FAIL abort_zero_weights: got %h want 0", result_a);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_max_unsigned();
    test_ramp();
    test_signed();
    test_backpressure();
    test_write_on_accept();
    test_write_drop();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
